// File: rtl/read_channel_scheduler.sv
// read_channel_scheduler: round-robin sharing of one AXI read channel
// among cache refill requesters, with RID steering and error flagging.
module read_channel_scheduler #(
  parameter int READ_MASTERS = 2,
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [READ_MASTERS-1:0]      m_arvalid,
  input  logic [READ_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [READ_MASTERS*4-1:0]    m_arlen,
  output logic [READ_MASTERS-1:0]      m_arready,
  output logic [READ_MASTERS-1:0]      m_rvalid,
  output logic [READ_MASTERS-1:0]      m_rlast,
  output logic [DATA_WIDTH-1:0]        m_rdata,
  input  logic [READ_MASTERS-1:0]      m_rready,
  output logic                         ARVALID,
  output logic [3:0]                   ARID,
  output logic [3:0]                   ARLEN,
  output logic [ADDR_WIDTH-1:0]        ARADDR,
  input  logic                         ARREADY,
  input  logic                         RVALID,
  input  logic                         RLAST,
  input  logic [3:0]                   RID,
  input  logic [DATA_WIDTH-1:0]        RDATA,
  output logic                         RREADY,
  output logic                         busy,
  output logic                         err
);

  localparam int IW = (READ_MASTERS > 1) ? $clog2(READ_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [IW-1:0]         win;
  logic                  found;
  logic                  rid_ok;
  logic                  match;
  logic                  hs;

  // Search starts just after the last winner so every requester
  // gets a turn before any one is served twice.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= READ_MASTERS; k++) begin
      idx = (int'(last_q) + k) % READ_MASTERS;
      if (!found && m_arvalid[idx]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  assign rid_ok = (RID == 4'(grant_q));
  assign match  = (state_q == DATA) && RVALID && rid_ok;
  assign hs     = match && m_rready[grant_q];

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rlast   = '0;
    if ((state_q == IDLE) && found && !rst)
      m_arready[win] = 1'b1;
    if (match) begin
      m_rvalid[grant_q] = 1'b1;
      m_rlast[grant_q]  = RLAST;
    end
  end

  assign RREADY  = hs;
  assign m_rdata = RDATA;
  assign ARVALID = (state_q == ADDR);
  assign ARID    = 4'(grant_q);
  assign ARLEN   = len_q;
  assign ARADDR  = addr_q;
  assign busy    = (state_q != IDLE);
  assign err     = err_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = win;
          addr_d  = m_araddr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
          len_d   = m_arlen[int'(win)*4 +: 4];
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ARREADY)
          state_d = DATA;
      end
      DATA: begin
        // A foreign RID is never consumed; the slave must fix it.
        if (RVALID && !rid_ok)
          err_d = 1'b1;
        if (hs) begin
          cnt_d = cnt_q + 4'd1;
          if (RLAST != (cnt_q == len_q))
            err_d = 1'b1;
          if (RLAST) begin
            last_d  = grant_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IW'(READ_MASTERS - 1);
      grant_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
